ntram_ctrl: RTL and testbench

NTRAM_CTRL -- requirements
Module: ntram_ctrl

---
 rtl/ntram_ctrl_if.sv | 34 +++
 rtl/ntram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ntram_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntram_ctrl_if.sv
// Host command/response and NoBL SRAM pin bundle for ntram_ctrl.
// The controller uses the slave modport; the host/pad side uses master.
interface ntram_ctrl_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 18
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_burst;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  logic [ADDR_W-1:0] Addr;
  logic              WEb, ADV, CKEb, CS1b, CS2, CS2b, Bwa_n, Bwb_n, OEb, ZZ, LBOb;
  logic [DATA_W-1:0] Dq_out;
  logic              Dq_oe;
  logic [DATA_W-1:0] Dq_in;

  modport slave (
    input  req_valid, req_we, req_burst, req_addr, req_wdata, req_be, Dq_in,
    output req_ready, rsp_valid, rsp_rdata,
    output Addr, WEb, ADV, CKEb, CS1b, CS2, CS2b, Bwa_n, Bwb_n, OEb, ZZ, LBOb, Dq_out, Dq_oe
  );

  modport master (
    output req_valid, req_we, req_burst, req_addr, req_wdata, req_be, Dq_in,
    input  req_ready, rsp_valid, rsp_rdata,
    input  Addr, WEb, ADV, CKEb, CS1b, CS2, CS2b, Bwa_n, Bwb_n, OEb, ZZ, LBOb, Dq_out, Dq_oe
  );
endinterface

// File: rtl/ntram_ctrl.sv
// Pipelined (NoBL/ZBT-style) synchronous SRAM controller with 4-beat linear burst
// tracking and an idle-driven ZZ sleep state machine.
module ntram_ctrl #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned IDLE_SLEEP = 16,
  parameter int unsigned WAKE_CYC   = 2
) (
  input logic      CLK,
  input logic      RSTb,
  ntram_ctrl_if.slave bus
);

  localparam int unsigned IdleW = $clog2(IDLE_SLEEP + 1);
  localparam int unsigned WakeW = $clog2(WAKE_CYC + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_SLEEP - 1);
  localparam logic [WakeW-1:0] WakeMax = WakeW'(WAKE_CYC - 1);

  typedef enum logic [1:0] {StActive, StSleep, StWake} pwr_e;

  pwr_e              st_q;
  logic              ready_q, zz_q, oeb_q;
  logic [IdleW-1:0]  idle_q;
  logic [WakeW-1:0]  wake_q;
  logic [ADDR_W-1:0] addr_q, base_q;
  logic              web_q, adv_q, cs1b_q, bwa_q, bwb_q;
  logic [1:0]        cnt_q;
  logic              dir_q, trk_vld_q;
  logic              w1_q, w2_q, r1_q, r2_q, r3_q;
  logic [DATA_W-1:0] wd1_q, wd2_q, dq_out_q, rdata_q;
  logic              dq_oe_q, rsp_valid_q;

  logic              accept, cont_ok, pipe_empty, sleep_go, zz_next;
  logic [1:0]        wrap_lo;
  logic [ADDR_W-1:0] wrap_addr;

  always_comb begin
    accept     = bus.req_valid & ready_q;
    wrap_lo    = base_q[1:0] + cnt_q + 2'd1;
    wrap_addr  = {base_q[ADDR_W-1:2], wrap_lo};
    cont_ok    = trk_vld_q && (dir_q == bus.req_we) && (cnt_q != 2'd3);
    pipe_empty = !(w1_q || w2_q || r1_q || r2_q || r3_q);
    sleep_go   = (st_q == StActive) && !bus.req_valid && pipe_empty && (idle_q == IdleMax);
    zz_next    = sleep_go || ((st_q == StSleep) && !bus.req_valid);
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      st_q        <= StActive;
      ready_q     <= 1'b0;
      idle_q      <= '0;
      wake_q      <= '0;
      zz_q        <= 1'b0;
      oeb_q       <= 1'b1;
      addr_q      <= '0;
      web_q       <= 1'b1;
      adv_q       <= 1'b0;
      cs1b_q      <= 1'b1;
      bwa_q       <= 1'b1;
      bwb_q       <= 1'b1;
      base_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      trk_vld_q   <= 1'b0;
      w1_q        <= 1'b0;
      w2_q        <= 1'b0;
      r1_q        <= 1'b0;
      r2_q        <= 1'b0;
      r3_q        <= 1'b0;
      wd1_q       <= '0;
      wd2_q       <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      // Default issue slot is a deselect; the data pipeline just shifts.
      addr_q      <= '0;
      web_q       <= 1'b1;
      adv_q       <= 1'b0;
      cs1b_q      <= 1'b1;
      bwa_q       <= 1'b1;
      bwb_q       <= 1'b1;
      w1_q        <= 1'b0;
      r1_q        <= 1'b0;
      w2_q        <= w1_q;
      wd2_q       <= wd1_q;
      r2_q        <= r1_q;
      r3_q        <= r2_q;
      dq_oe_q     <= w2_q;
      dq_out_q    <= w2_q ? wd2_q : '0;
      rsp_valid_q <= r3_q;
      if (r3_q) rdata_q <= bus.Dq_in;
      zz_q        <= zz_next;
      oeb_q       <= w2_q | zz_next;

      if (accept) begin
        cs1b_q    <= 1'b0;
        web_q     <= ~bus.req_we;
        bwa_q     <= bus.req_we ? ~bus.req_be[0] : 1'b1;
        bwb_q     <= bus.req_we ? ~bus.req_be[1] : 1'b1;
        dir_q     <= bus.req_we;
        trk_vld_q <= 1'b1;
        w1_q      <= bus.req_we;
        r1_q      <= ~bus.req_we;
        wd1_q     <= bus.req_wdata;
        if (bus.req_burst && cont_ok) begin
          adv_q <= 1'b1;
          cnt_q <= cnt_q + 2'd1;
        end else begin
          // A continue that cannot ride the SRAM's burst counter is reissued as a load.
          addr_q <= bus.req_burst ? wrap_addr : bus.req_addr;
          base_q <= bus.req_burst ? wrap_addr : bus.req_addr;
          cnt_q  <= 2'd0;
        end
      end

      unique case (st_q)
        StActive: begin
          if (sleep_go) begin
            st_q      <= StSleep;
            ready_q   <= 1'b0;
            idle_q    <= '0;
            trk_vld_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
            if (bus.req_valid) idle_q <= '0;
            else if (idle_q != IdleMax) idle_q <= idle_q + 1'b1;
          end
        end
        StSleep: begin
          ready_q <= 1'b0;
          if (bus.req_valid) begin
            st_q   <= StWake;
            wake_q <= '0;
          end
        end
        StWake: begin
          if (wake_q == WakeMax) begin
            st_q    <= StActive;
            ready_q <= 1'b1;
            idle_q  <= '0;
          end else begin
            wake_q  <= wake_q + 1'b1;
          end
        end
        default: st_q <= StActive;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.Addr      = addr_q;
  assign bus.WEb       = web_q;
  assign bus.ADV       = adv_q;
  assign bus.CKEb      = 1'b0;
  assign bus.CS1b      = cs1b_q;
  assign bus.CS2       = 1'b1;
  assign bus.CS2b      = 1'b0;
  assign bus.Bwa_n     = bwa_q;
  assign bus.Bwb_n     = bwb_q;
  assign bus.OEb       = oeb_q;
  assign bus.ZZ        = zz_q;
  assign bus.LBOb      = 1'b0;
  assign bus.Dq_out    = dq_out_q;
  assign bus.Dq_oe     = dq_oe_q;

endmodule

// File: tb/tb_ntram_ctrl.sv
// Self-checking bench for ntram_ctrl: pin-level SRAM model plus a host-side read scoreboard.
module tb_ntram_ctrl;
  logic clk;
  logic rstb;
  int   checks = 0;
  int   errors = 0;

  ntram_ctrl_if #(.ADDR_W(20), .DATA_W(18)) bus ();

  ntram_ctrl #(.ADDR_W(20), .DATA_W(18), .IDLE_SLEEP(16), .WAKE_CYC(2)) dut (
    .CLK (clk),
    .RSTb(rstb),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Host-side reference memory and expected read data queue.
  logic [17:0] hmem [logic [19:0]];
  logic [17:0] smem [logic [19:0]];
  logic [17:0] exp_q [$];

  function automatic logic [17:0] init_val(input logic [19:0] a);
    return {a[8:0], ~a[8:0]};
  endfunction

  function automatic logic [17:0] hrd(input logic [19:0] a);
    return hmem.exists(a) ? hmem[a] : init_val(a);
  endfunction

  function automatic logic [17:0] srd(input logic [19:0] a);
    return smem.exists(a) ? smem[a] : init_val(a);
  endfunction

  // SRAM pin model: command seen in cycle I, data phase in cycle I+2.
  logic        d1_v, d1_we, d2_v, d2_we;
  logic [19:0] d1_a, d2_a, m_addr;
  logic [1:0]  d1_be, d2_be;
  initial begin
    logic        c_v;
    logic [17:0] w;
    d1_v = 1'b0; d2_v = 1'b0; d1_we = 1'b0; d2_we = 1'b0;
    d1_a = '0; d2_a = '0; d1_be = '0; d2_be = '0; m_addr = '0;
    bus.Dq_in = '0;
    forever begin
      @(negedge clk);
      if (!rstb) begin
        d1_v = 1'b0; d2_v = 1'b0; bus.Dq_in = '0;
      end else begin
        if (d2_v) begin
          if (d2_we) begin
            checks++;
            if (bus.Dq_oe !== 1'b1) begin
              errors++;
              $display("FAIL sram_wr_oe addr=%h Dq_oe=%b required 1", d2_a, bus.Dq_oe);
            end else begin
              w = srd(d2_a);
              if (d2_be[0]) w[8:0] = bus.Dq_out[8:0];
              if (d2_be[1]) w[17:9] = bus.Dq_out[17:9];
              smem[d2_a] = w;
            end
          end else begin
            bus.Dq_in = srd(d2_a);
          end
        end
        c_v = 1'b0;
        if (bus.ADV === 1'b1) begin
          m_addr = {m_addr[19:2], m_addr[1:0] + 2'd1};
          c_v = 1'b1;
        end else if (bus.CS1b === 1'b0) begin
          m_addr = bus.Addr;
          c_v = 1'b1;
        end
        d2_v = d1_v; d2_we = d1_we; d2_a = d1_a; d2_be = d1_be;
        d1_v = c_v; d1_we = ~bus.WEb; d1_a = m_addr; d1_be = {~bus.Bwb_n, ~bus.Bwa_n};
      end
    end
  end

  // Response monitor: every rsp_valid pops the next expected read.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got %h with no read outstanding", bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_rdata !== e) begin
            errors++;
            $display("FAIL rsp_data got %h required %h", bus.rsp_rdata, e);
          end
        end
      end
    end
  end

  // Presents one command and returns #1 after the accepting edge (cycle I).
  task automatic send(input logic we, input logic burst, input logic [19:0] a,
                      input logic [17:0] d, input logic [1:0] be, input logic [19:0] exp_a,
                      output int stalls);
    logic [17:0] w;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_burst = burst;
    bus.req_addr = a; bus.req_wdata = d; bus.req_be = be;
    stalls = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout req_ready=%b required 1", bus.req_ready);
    end else if (we) begin
      w = hrd(exp_a);
      if (be[0]) w[8:0] = d[8:0];
      if (be[1]) w[17:9] = d[17:9];
      hmem[exp_a] = w;
    end else begin
      exp_q.push_back(hrd(exp_a));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0; bus.req_burst = 1'b0; bus.req_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] v;
    rstb = 1'b0;
    idle_req();
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
    #12;
    v = {bus.req_ready, bus.rsp_valid, bus.WEb, bus.ADV, bus.CKEb, bus.CS1b, bus.CS2, bus.CS2b,
         bus.Bwa_n, bus.Bwb_n, bus.OEb, bus.ZZ, bus.LBOb, bus.Dq_oe};
    checks++;
    if (v !== 14'b00100110111000) begin
      errors++;
      $display("FAIL reset_ctrl got %b required %b", v, 14'b00100110111000);
    end
    checks++;
    if ({bus.Addr, bus.Dq_out, bus.rsp_rdata} !== 56'd0) begin
      errors++;
      $display("FAIL reset_buses Addr=%h Dq_out=%h rdata=%h required 0", bus.Addr, bus.Dq_out,
               bus.rsp_rdata);
    end
    @(negedge clk);
    rstb = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge got %b required 0", bus.req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_first_edge got %b required 1", bus.req_ready);
    end
  endtask

  task automatic test_basic_rw();
    int st;
    send(1'b1, 1'b0, 20'hE38E4, 18'h0000F, 2'b11, 20'hE38E4, st);
    checks++;
    if ({bus.WEb, bus.ADV, bus.CS1b, bus.Bwa_n, bus.Bwb_n, bus.Addr} !== {5'b00000, 20'hE38E4})
    begin
      errors++;
      $display("FAIL wr_issue got WEb/ADV/CS1b/Bw=%b%b%b%b%b Addr=%h required 00000 E38E4",
               bus.WEb, bus.ADV, bus.CS1b, bus.Bwa_n, bus.Bwb_n, bus.Addr);
    end
    send(1'b0, 1'b0, 20'hE38E4, 18'h0, 2'b11, 20'hE38E4, st);
    checks++;
    if ({bus.WEb, bus.ADV, bus.CS1b, bus.Bwa_n, bus.Bwb_n, bus.Addr} !== {5'b10011, 20'hE38E4})
    begin
      errors++;
      $display("FAIL rd_issue got WEb/ADV/CS1b/Bw=%b%b%b%b%b Addr=%h required 10011 E38E4",
               bus.WEb, bus.ADV, bus.CS1b, bus.Bwa_n, bus.Bwb_n, bus.Addr);
    end
    idle_req();
    @(posedge clk); #1;
    checks++;
    if ({bus.Dq_oe, bus.OEb, bus.Dq_out} !== {2'b11, 18'h0000F}) begin
      errors++;
      $display("FAIL wr_data Dq_oe=%b OEb=%b Dq_out=%h required 1 1 0000F", bus.Dq_oe, bus.OEb,
               bus.Dq_out);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.Dq_oe, bus.OEb, bus.CS1b, bus.rsp_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL after_wr Dq_oe/OEb/CS1b/rsp_valid=%b%b%b%b required 0010", bus.Dq_oe,
               bus.OEb, bus.CS1b, bus.rsp_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 18'h0000F}) begin
      errors++;
      $display("FAIL rd_latency rsp_valid=%b rdata=%h required 1 0000F", bus.rsp_valid,
               bus.rsp_rdata);
    end
  endtask

  task automatic test_burst();
    int          st;
    logic [17:0] bd  [5] = '{18'h0000F, 18'h0001F, 18'h0002F, 18'h0003F, 18'h0004F};
    logic [19:0] ea  [5] = '{20'hE38E4, 20'hE38E5, 20'hE38E6, 20'hE38E7, 20'hE38E4};
    logic [19:0] pa  [5] = '{20'hE38E4, 20'h0, 20'h0, 20'h0, 20'hE38E4};
    logic        adv [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      send(1'b1, i != 0, (i == 0) ? 20'hE38E4 : 20'h0, bd[i], 2'b11, ea[i], st);
      checks++;
      if ({bus.ADV, bus.Addr, bus.WEb} !== {adv[i], pa[i], 1'b0}) begin
        errors++;
        $display("FAIL burst_beat%0d ADV=%b Addr=%h WEb=%b required %b %h 0", i, bus.ADV,
                 bus.Addr, bus.WEb, adv[i], pa[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b0, i != 0, 20'hE38E4, 18'h0, 2'b00, ea[i], st);
      checks++;
      if (bus.ADV !== (i != 0)) begin
        errors++;
        $display("FAIL burst_rd%0d ADV=%b required %b", i, bus.ADV, i != 0);
      end
    end
    idle_req();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_interleave();
    int          st;
    logic        we [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [19:0] ad [6] = '{20'h10, 20'h10, 20'h20, 20'h20, 20'h10, 20'h10};
    logic [17:0] wd [6] = '{18'h12345, 18'h0, 18'h2AAAA, 18'h0, 18'h3FFFF, 18'h0};
    logic [1:0]  be [6] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    for (int i = 0; i < 6; i++) begin
      send(we[i], 1'b0, ad[i], wd[i], be[i], ad[i], st);
      checks++;
      if (st != 0 || bus.req_ready !== 1'b1 || bus.WEb !== ~we[i]) begin
        errors++;
        $display("FAIL interleave%0d stalls=%0d ready=%b WEb=%b required 0 1 %b", i, st,
                 bus.req_ready, bus.WEb, ~we[i]);
      end
    end
    idle_req();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_dir_change();
    int st;
    send(1'b1, 1'b0, 20'h00040, 18'h11111, 2'b11, 20'h00040, st);
    send(1'b1, 1'b1, 20'h0, 18'h22222, 2'b11, 20'h00041, st);
    send(1'b0, 1'b1, 20'h0, 18'h0, 2'b00, 20'h00042, st);
    checks++;
    if ({bus.ADV, bus.WEb, bus.CS1b, bus.Addr} !== {3'b010, 20'h00042}) begin
      errors++;
      $display("FAIL dir_change ADV/WEb/CS1b=%b%b%b Addr=%h required 010 00042", bus.ADV,
               bus.WEb, bus.CS1b, bus.Addr);
    end
    send(1'b0, 1'b1, 20'h0, 18'h0, 2'b00, 20'h00043, st);
    checks++;
    if (bus.ADV !== 1'b1) begin
      errors++;
      $display("FAIL dir_change_cont ADV=%b required 1", bus.ADV);
    end
    idle_req();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_abort_sleep();
    int st;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({bus.ZZ, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL pre_abort ZZ=%b ready=%b required 0 1", bus.ZZ, bus.req_ready);
    end
    send(1'b0, 1'b0, 20'h00080, 18'h0, 2'b00, 20'h00080, st);
    checks++;
    if ({bus.ZZ, bus.CS1b, bus.ADV, bus.Addr} !== {3'b000, 20'h00080}) begin
      errors++;
      $display("FAIL abort_accept ZZ/CS1b/ADV=%b%b%b Addr=%h required 000 00080", bus.ZZ,
               bus.CS1b, bus.ADV, bus.Addr);
    end
  endtask

  task automatic test_sleep_wake();
    int st;
    idle_req();
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (bus.ZZ !== 1'b0) begin
      errors++;
      $display("FAIL sleep_early ZZ=%b required 0", bus.ZZ);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.ZZ, bus.OEb, bus.req_ready, bus.CS1b} !== 4'b1101) begin
      errors++;
      $display("FAIL sleep_entry ZZ/OEb/ready/CS1b=%b%b%b%b required 1101", bus.ZZ, bus.OEb,
               bus.req_ready, bus.CS1b);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_burst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.ZZ, bus.req_ready} !== 2'b00) begin
        errors++;
        $display("FAIL wake%0d ZZ=%b ready=%b required 0 0", i, bus.ZZ, bus.req_ready);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.ZZ, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wake_done ZZ=%b ready=%b required 0 1", bus.ZZ, bus.req_ready);
    end
    send(1'b0, 1'b1, 20'h0, 18'h0, 2'b00, 20'h00081, st);
    checks++;
    if ({bus.ADV, bus.WEb, bus.CS1b, bus.Addr} !== {3'b010, 20'h00081}) begin
      errors++;
      $display("FAIL wake_cont ADV/WEb/CS1b=%b%b%b Addr=%h required 010 00081", bus.ADV,
               bus.WEb, bus.CS1b, bus.Addr);
    end
    idle_req();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int          st;
    int          seen;
    logic [13:0] v;
    send(1'b0, 1'b0, 20'h00010, 18'h0, 2'b00, 20'h00010, st);
    send(1'b0, 1'b0, 20'h00020, 18'h0, 2'b00, 20'h00020, st);
    idle_req();
    #2;
    rstb = 1'b0;
    exp_q.delete();
    #1;
    v = {bus.req_ready, bus.rsp_valid, bus.WEb, bus.ADV, bus.CKEb, bus.CS1b, bus.CS2, bus.CS2b,
         bus.Bwa_n, bus.Bwb_n, bus.OEb, bus.ZZ, bus.LBOb, bus.Dq_oe};
    checks++;
    if (v !== 14'b00100110111000 || bus.Addr !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid ctrl=%b Addr=%h required %b 00000", v, bus.Addr,
               14'b00100110111000);
    end
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_discard rsp_valid pulses=%0d required 0", seen);
    end
  endtask

  initial begin
    rstb = 1'b0;
    test_reset();
    test_basic_rw();
    test_burst();
    test_interleave();
    test_dir_change();
    test_abort_sleep();
    test_sleep_wake();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads outstanding=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
